// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: opcodes, ALU ops, control word, ID/EX state.
// Constants bounding the load-use bubble count and naming register x0.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef struct packed {
        rv32i_opcode opcode;
        alu_ops      aluop;
        logic [2:0]  funct3;
        logic        load_regfile;
        logic        read;
        logic        write;
        logic [1:0]  regfilemux_sel;
        logic        alumux1_sel;
        logic [2:0]  alumux2_sel;
        logic [2:0]  cmpop;
    } rv32i_control_word;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } id_ex_state_t;

    localparam int         LOAD_USE_BUBBLES_MAX = 3;
    localparam logic [4:0] X0_IDX               = 5'd0;

    function automatic logic uses_rs1(rv32i_opcode op);
        return !(op == op_lui || op == op_auipc || op == op_jal);
    endfunction

    function automatic logic uses_rs2(rv32i_opcode op);
        return op == op_br || op == op_store || op == op_reg;
    endfunction

endpackage

// File: rtl/ir_field_decode.sv
// Combinational extraction of register indices and sign-extended
// immediates from a raw RV32I instruction word.
module ir_field_decode (
    input  logic [31:0] instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] i_imm,
    output logic [31:0] s_imm,
    output logic [31:0] b_imm,
    output logic [31:0] u_imm,
    output logic [31:0] j_imm
);

    logic unused_opcode;

    assign unused_opcode = ^instr[6:0];

    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign rd  = instr[11:7];

    assign i_imm = {{21{instr[31]}}, instr[30:20]};
    assign s_imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
    assign b_imm = {{20{instr[31]}}, instr[7], instr[30:25],
                    instr[11:8], 1'b0};
    assign u_imm = {instr[31:12], 12'b0};
    assign j_imm = {{12{instr[31]}}, instr[19:12], instr[20],
                    instr[30:21], 1'b0};

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, stall and flush.
// Optional ID_EX_PERF_CNT_EN adds bubble and flush event counters.
module id_ex_stage
    import rv32i_types::*;
#(
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_instr,
    input  rv32i_control_word id_ctrl,
    input  logic [31:0]       id_rs1_data,
    input  logic [31:0]       id_rs2_data,
    input  logic              ex_stall,
    input  logic              ex_flush,
    output logic              id_hold,
    output logic              ex_valid,
    output rv32i_control_word ex_ctrl,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_rs1_data,
    output logic [31:0]       ex_rs2_data,
    output logic [4:0]        ex_rs1_idx,
    output logic [4:0]        ex_rs2_idx,
    output logic [4:0]        ex_rd,
    output logic [31:0]       ex_i_imm,
    output logic [31:0]       ex_s_imm,
    output logic [31:0]       ex_b_imm,
    output logic [31:0]       ex_u_imm,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]       perf_bubbles,
    output logic [31:0]       perf_flushes,
`endif
    output logic [31:0]       ex_j_imm
);

    localparam int BUB_N =
        (LOAD_USE_BUBBLES > LOAD_USE_BUBBLES_MAX) ? LOAD_USE_BUBBLES_MAX :
        (LOAD_USE_BUBBLES < 1) ? 1 : LOAD_USE_BUBBLES;
    localparam logic [1:0] BUB_INIT = 2'(BUB_N - 1);

    logic [4:0]   rs1, rs2, rd;
    logic [31:0]  i_imm, s_imm, b_imm, u_imm, j_imm;
    id_ex_state_t state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         rs1_hit, rs2_hit, hazard;
    logic         load_bubble, load_id;

    ir_field_decode u_dec (
        .instr (id_instr),
        .rs1   (rs1),
        .rs2   (rs2),
        .rd    (rd),
        .i_imm (i_imm),
        .s_imm (s_imm),
        .b_imm (b_imm),
        .u_imm (u_imm),
        .j_imm (j_imm)
    );

    assign rs1_hit = uses_rs1(id_ctrl.opcode) && rs1 != X0_IDX
                     && rs1 == ex_rd;
    assign rs2_hit = uses_rs2(id_ctrl.opcode) && rs2 != X0_IDX
                     && rs2 == ex_rd;
    assign hazard  = ex_valid && ex_ctrl.opcode == op_load
                     && ex_ctrl.load_regfile && ex_rd != X0_IDX
                     && id_valid && (rs1_hit || rs2_hit);

    assign id_hold = ex_stall
                     | (!ex_flush & ((hazard && state_q == RUN)
                                     | state_q == BUBBLE));

    // Next state: stall > flush > pending bubbles > new hazard > advance.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_bubble = 1'b0;
        load_id     = 1'b0;
        if (ex_stall) begin
            state_d = state_q;
        end else if (ex_flush) begin
            load_bubble = 1'b1;
            cnt_d       = 2'd0;
            state_d     = RUN;
        end else if (state_q == BUBBLE) begin
            load_bubble = 1'b1;
            cnt_d       = cnt_q - 2'd1;
            state_d     = (cnt_q == 2'd1) ? RUN : BUBBLE;
        end else if (hazard) begin
            load_bubble = 1'b1;
            cnt_d       = BUB_INIT;
            state_d     = (BUB_INIT != 2'd0) ? BUBBLE : RUN;
        end else begin
            load_id = 1'b1;
        end
    end

    // Bubble-state register and remaining-bubble counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ID/EX pipeline register; a bubble only clears valid and control.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1_idx  <= '0;
            ex_rs2_idx  <= '0;
            ex_rd       <= '0;
            ex_i_imm    <= '0;
            ex_s_imm    <= '0;
            ex_b_imm    <= '0;
            ex_u_imm    <= '0;
            ex_j_imm    <= '0;
        end else if (load_bubble) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (load_id) begin
            ex_valid    <= id_valid;
            ex_ctrl     <= id_ctrl;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_rs1_idx  <= rs1;
            ex_rs2_idx  <= rs2;
            ex_rd       <= rd;
            ex_i_imm    <= i_imm;
            ex_s_imm    <= s_imm;
            ex_b_imm    <= b_imm;
            ex_u_imm    <= u_imm;
            ex_j_imm    <= j_imm;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // Count hazard bubbles and accepted flushes; both wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bubbles <= '0;
            perf_flushes <= '0;
        end else begin
            if (load_bubble && !ex_flush)
                perf_bubbles <= perf_bubbles + 32'd1;
            if (ex_flush && !ex_stall)
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Sits between the decode control ROM and the execute stage of the 5-stage RV32I pipeline.
- Registers the decoded control word, PC, register operands and extracted immediates into the ID/EX pipeline register.
- Detects load-use hazards and inserts bubbles, holding IF/ID while it does.
- Honours execute-stage stalls and branch/jump redirect flushes.

Parameters:
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1..3). Use 1 when MEM/WB forwarding exists.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  32  PC of the ID instruction.
- id_instr  in  32  raw instruction word.
- id_ctrl  in  rv32i_control_word  control word from the decode ROM.
- id_rs1_data  in  32  regfile read port A.
- id_rs2_data  in  32  regfile read port B.
- ex_stall  in  1  downstream (memory) stall; hold the ID/EX register.
- ex_flush  in  1  redirect from EX; kill the ID instruction.
- id_hold  out  1  IF/ID must not advance (combinational).
- ex_valid  out  1  EX slot holds a real instruction.
- ex_ctrl  out  rv32i_control_word  registered control word.
- ex_pc  out  32  registered PC.
- ex_rs1_data  out  32  registered operand A.
- ex_rs2_data  out  32  registered operand B.
- ex_rs1_idx  out  5  registered rs1 index (for forwarding).
- ex_rs2_idx  out  5  registered rs2 index (for forwarding).
- ex_rd  out  5  registered destination index.
- ex_i_imm  out  32  registered I-type immediate.
- ex_s_imm  out  32  registered S-type immediate.
- ex_b_imm  out  32  registered B-type immediate.
- ex_u_imm  out  32  registered U-type immediate.
- ex_j_imm  out  32  registered J-type immediate.

Behaviour:
- Reset: all ex_* outputs are 0, ex_ctrl is all-zero (a bubble), the bubble counter is 0, id_hold is 0.
- Bubble definition: ex_valid=0 and ex_ctrl=0. An all-zero control word has load_regfile=0 and write=0.
- Source use is decided from the opcode:
  - rs1 is used by all opcodes except lui, auipc and jal.
  - rs2 is used by br, store and reg.
  - An index of x0 never matches.
- Hazard (combinational): all of the following hold:
  - ex_valid and ex_ctrl.opcode==op_load and ex_ctrl.load_regfile and ex_rd!=0;
  - id_valid;
  - (rs1 used and rs1==ex_rd) or (rs2 used and rs2==ex_rd).
- FSM states:
  - RUN (cnt==0).
  - BUBBLE (cnt>0). While in BUBBLE, the hazard is tracked by the counter alone, because the load has already left EX.
- Per-edge priority:
  1. rst.
  2. ex_stall: ID/EX register, counter and state all hold.
  3. ex_flush: load a bubble, cnt←0, go to RUN.
  4. RUN with hazard: load a bubble, cnt←LOAD_USE_BUBBLES-1, go to BUBBLE if the new cnt>0.
  5. BUBBLE: load a bubble, decrement cnt, go to RUN when cnt reaches 0.
  6. Otherwise: load the ID fields; ex_valid←id_valid.
- id_hold = ex_stall | (!ex_flush & (hazard-in-RUN | state==BUBBLE)).
- A flush overrides a pending hazard. A stall overrides a flush; the redirect source keeps ex_flush high until ex_stall drops.
- Reset asserted mid-bubble: returns to RUN on the next edge.
- Latency: 1 cycle from ID to EX with no hazard.
- Immediates are sign-extended per the RV32I formats. u_imm = {instr[31:12], 12'b0}.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, adds two ports:
  - perf_bubbles  out 32: counts edges where a hazard or counter bubble was loaded and ex_stall=0. Excludes flush bubbles.
  - perf_flushes  out 32: counts edges with ex_flush & !ex_stall.
- Both counters reset to 0 and wrap at 2^32.
- When undefined: no counters and no ports.

Decomposition:
- rv32i_types holds:
  - rv32i_control_word, rv32i_opcode;
  - a new typedef id_ex_state_t {RUN, BUBBLE};
  - the constants LOAD_USE_BUBBLES_MAX=3 and X0_IDX=5'd0.
- Sub-module ir_field_decode (combinational): extracts rs1, rs2, rd and the five immediates from the instruction word. It is instantiated once in this stage.

Test Plan:
- add x3,x1,x2 then nop with no stall: next edge ex_valid=1, ex_rd=3, ex_ctrl.aluop=alu_add, id_hold=0.
- lw x5,0(x1) in EX, add x6,x5,x2 in ID:
  - id_hold=1 for 1 cycle, then a bubble (ex_valid=0);
  - then the add appears in EX with ex_rs1_idx=5.
- LOAD_USE_BUBBLES=3 with the same pair: id_hold high for 3 cycles, then 3 bubbles, then the add.
- lw x0,0(x1) then add x6,x0,x2: no hazard, no bubble.
- lui x5 then an ID instruction reading rs1=x5 behind a load to x5: no hazard, because lui does not use rs1.
- Hazard cycle with ex_flush=1: a bubble loads, cnt=0, id_hold=0.
- ex_stall=1 for 4 cycles during BUBBLE with cnt=2: outputs and cnt frozen, id_hold=1. Resumes decrementing after the stall.
- ID_EX_PERF_CNT_EN defined, 2 load-use hazards and 1 flush: perf_bubbles=2, perf_flushes=1.
